// File: rtl/timer_counter.sv
// Bus-mapped down-counter timer with one-shot and auto-reload modes.
// Raises an interrupt flag when COUNT reaches zero; the flag is gated by CTRL.IM onto irq.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic enable;
    logic auto_reload;
    logic irq_mask;
    logic ctrl_we;
    logic preset_we;
    logic flag_set;

    assign enable      = ctrl_q[0];
    assign auto_reload = (ctrl_q[2:1] == 2'b01);
    assign irq_mask    = ctrl_q[3];
    assign ctrl_we     = we && (addr[3:2] == 2'b00);
    assign preset_we   = we && (addr[3:2] == 2'b01);

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        flag_set   = 1'b0;

        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d  = 32'd0;
                    flag_set = 1'b1;
                    state_d  = StInt;
                end
            end
            StInt: begin
                if (auto_reload) begin
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Bus write overrides the INT-state enable clear; a same-cycle flag set beats the ack.
        if (ctrl_we) begin
            ctrl_d     = wdata[3:0];
            irq_flag_d = 1'b0;
        end
        if (flag_set) begin
            irq_flag_d = 1'b1;
        end
        if (preset_we) begin
            preset_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr[3:2])
            2'b00:   rdata = {28'd0, ctrl_q};
            2'b01:   rdata = preset_q;
            2'b10:   rdata = count_q;
            default: rdata = 32'd0;
        endcase
    end

    assign irq = irq_mask & irq_flag_q;

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have parameter none; register map fixed: CTRL @0x0, PRESET @0x4, COUNT @0x8 (byte offsets, addr[3:2] decoded).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port addr  input  4  byte offset of register; addr[1:0] ignored.
REQ-005 SHALL have port we  input  1  write strobe, sampled on clk rising edge.
REQ-006 SHALL have port wdata  input  32  write data.
REQ-007 SHALL have port rdata  output  32  combinational read of register at addr.
REQ-008 SHALL have port irq  output  1  interrupt request to the CP0 hardware-interrupt input.

Function
REQ-009 SHALL hold CTRL[3:0]: bit0 Enable, bits2:1 Mode (00 one-shot, 01 auto-reload, 10/11 behave as 00), bit3 IM (irq mask); CTRL[31:4] read as 0.
REQ-010 SHALL implement a 32-bit PRESET (R/W) and a 32-bit COUNT (read-only; writes to 0x8 ignored).
REQ-011 SHALL return on rdata: CTRL zero-extended, PRESET, COUNT for offsets 0x0/0x4/0x8; 0 for 0xC.
REQ-012 SHALL write CTRL <= {28'b0, wdata[3:0]} / PRESET <= wdata when we=1 at the matching offset.
REQ-013 SHALL drive irq = IM & irq_flag, purely combinational from registers.
REQ-014 SHALL run FSM with states IDLE, LOAD, CNT, INT; one transition per cycle max.
REQ-015 IDLE: Enable=1 -> LOAD; else stay.
REQ-016 LOAD: COUNT <= PRESET; -> CNT.
REQ-017 CNT: Enable=0 -> IDLE, COUNT frozen; else COUNT>1 -> COUNT-1, stay; else (COUNT 0 or 1) COUNT <= 0, irq_flag <= 1, -> INT.
REQ-018 INT, one-shot mode: Enable <= 0, irq_flag held at 1, -> IDLE.
REQ-019 INT, auto-reload mode: irq_flag <= 0 (one-cycle flag), -> IDLE; Enable stays 1 so reload follows via LOAD.
REQ-020 SHALL clear irq_flag on any CTRL write; this is the one-shot acknowledge.
REQ-021 Latency: CTRL write enabling at edge E0 with PRESET=N -> irq_flag set at edge E(max(N,1)+2); auto-reload period max(N,1)+3 cycles.
REQ-022 Simultaneous bus CTRL write and INT-state Enable clear: bus write wins for all CTRL bits; irq_flag still cleared by REQ-020 unless set in same cycle (set wins).
REQ-023 CTRL write re-enabling during CNT SHALL continue from current COUNT without reload; PRESET write during CNT takes effect at next LOAD only.
REQ-024 COUNT arithmetic SHALL be unsigned 32-bit, never wraps below 0.

Reset
REQ-025 SHALL on reset=0 (asynchronous) force CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state IDLE; thus irq=0 and rdata reflects zeros.
REQ-026 Reset asserted mid-count SHALL abort immediately; after release block idles until Enable written.

Verification
REQ-027 PRESET=3, write CTRL=0x9 at E0 -> COUNT 3,2,1,0 at E2..E5; irq=1 from E5; CTRL reads 0x8 after E6; irq stays 1.
REQ-028 Continuing REQ-027, write CTRL=0x8 -> irq=0 next cycle, COUNT stays 0, state IDLE.
REQ-029 PRESET=2, CTRL=0xB (auto-reload, IM) -> irq one-cycle pulses every 5 cycles, COUNT reloads to 2 each period.
REQ-030 PRESET=0 and PRESET=1, CTRL=0x9 -> irq set at E3 in both cases.
REQ-031 CTRL=0x1 (IM=0), PRESET=2 -> COUNT reaches 0, irq stays 0; then write CTRL=0x8 -> irq 0 (flag cleared).
REQ-032 Pull reset low while COUNT=5 in CNT -> all registers 0, irq 0 without waiting for clk; no activity after release.
